regfile_tagged: RTL and testbench
=================================

Name: regfile_tagged

Overview:
- Architectural register file with per-register rename tags; the consumer end of the reorder buffer's commit/CDB broadcast.
- The issue stage sends a rename (rd gets a ROB tag) when it pushes an instruction into the ROB.
- The ROB head commit (cdb_*) writes the value back and clears the tag.
- Two combinational read ports give value or pending tag to issue/RS, with same-cycle commit bypass.

Parameters:
- XLEN, 32, data width.
- REG_NUM, 32, number of architectural registers (index width 5).
- TAG_W, 4, ROB tag width; tag 0 = none/ready.

Ports:
- clk_in  input  1  clock
- rst_in  input  1  asynchronous active-high reset
- rdy_in  input  1  global enable; low = hold all state
- rename_valid  input  1  issue renames rd this cycle
- rename_rd_idx  input  5  destination register
- rename_tag  input  TAG_W  ROB tag assigned (never 0 when valid)
- cdb_active  input  1  ROB head commit valid
- cdb_tag  input  TAG_W  committing tag
- cdb_val  input  XLEN  committed value
- cdb_rd_idx  input  5  committed destination
- predict_fail  input  1  flush; all pending tags discarded
- rs1_idx  input  5  read port 1 index
- rs1_val  output  XLEN  value (valid when rs1_tag==0)
- rs1_tag  output  TAG_W  pending producer tag, 0 = ready
- rs2_idx, rs2_val, rs2_tag  same as port 1

Behaviour:
- State: val[REG_NUM] of XLEN, tag[REG_NUM] of TAG_W.
- Reset (async on rst_in rise): all val=0, tag=0. Read outputs are therefore 0/0.
- rdy_in low: no state updates. Reads stay live.
- Commit, posedge with rdy_in, cdb_active, cdb_rd_idx!=0:
  - val[rd] <= cdb_val.
  - tag[rd] <= 0 only if tag[rd]==cdb_tag; otherwise a younger rename stands and the tag is kept.
- Rename, posedge with rdy_in, rename_valid, !predict_fail, rename_rd_idx!=0: tag[rd] <= rename_tag.
- Same cycle, same register, rename and commit: value is written and the tag becomes rename_tag (rename wins).
- predict_fail (with rdy_in): all tags <= 0 and rename is ignored. A commit in the same cycle still writes its value.
- x0: val[0] and tag[0] are constant 0. Writes and renames to x0 are dropped.
- Reads are combinational, one cycle of zero latency:
  - Default: rsN_val = val[idx], rsN_tag = tag[idx].
  - Bypass: if cdb_active && idx!=0 && tag[idx]!=0 && tag[idx]==cdb_tag, then rsN_val = cdb_val and rsN_tag = 0.
  - Reads reflect pre-rename state. An instruction renaming rd in the same cycle it reads rd sees the older producer.
- Both read ports are independent and may use the same index.

Optional Feature:
- Macro REGFILE_COMMIT_TRACE_EN.
- Defined: each committing cycle ($display in a simulation-only block) prints "RF: x<idx> <= <val> tag=<tag> cleared=<0|1>".
- Undefined: no display code. Hardware is identical either way.

Decomposition:
- Shared macros header: ROB_SIZE, ROB_SIZE_W, TAG_W, TAG_NONE (=0), REG_NUM, XLEN.
- One sub-module, regfile_read_bypass: takes idx, stored val/tag and the cdb signals, produces val/tag. Instantiated twice.

Test Plan:
- Reset: assert rst_in mid-clock → immediately rs1_idx=5 gives rs1_val=0, rs1_tag=0.
- Rename then commit:
  - rename x3 tag 2 → next cycle rs1(x3) tag=2.
  - cdb_active tag 2 rd 3 val 0xDEADBEEF → same cycle rs1 gives 0xDEADBEEF/tag 0 (bypass); next cycle stored, tag 0.
- Stale commit: rename x7 tag 1, then x7 tag 4. Commit tag 1 rd 7 val 0x11 → val[7]=0x11, tag stays 4, rs2(x7) tag=4.
- Simultaneous: rename x9 tag 6 and commit rd 9 tag 6 (pre-tag 6) val 0x55 in the same cycle → val[9]=0x55, tag[9]=6.
- Flush: tags pending on x1,x2; predict_fail with rename x4 tag 3 and commit rd 1 val 0x77 → all tags 0, tag[4]=0, val[1]=0x77.
- x0/rdy: rename x0 tag 5 and commit rd 0 val 0x99 → rs1(x0)=0/0. With rdy_in=0, rename x8 tag 2 → tag[8] unchanged (0).

Source files
------------

// File: rtl/regfile_tagged_pkg.sv
// Shared constants and types for the tagged architectural register file.
// Optional build macro: REGFILE_COMMIT_TRACE_EN (commit trace printout in simulation).
package regfile_tagged_pkg;

  localparam int XLEN       = 32;
  localparam int REG_NUM    = 32;
  localparam int IDX_W      = 5;
  localparam int ROB_SIZE   = 16;
  localparam int ROB_SIZE_W = 4;
  localparam int TAG_W      = ROB_SIZE_W;

  // Tag value meaning "no pending producer, value is ready".
  localparam logic [TAG_W-1:0] TAG_NONE = '0;

  // One read-port response: value plus pending producer tag.
  typedef struct packed {
    logic [XLEN-1:0]  val;
    logic [TAG_W-1:0] tag;
  } rd_rsp_t;

endpackage

// File: rtl/regfile_tagged_if.sv
// Issue/commit/read bundle of the tagged register file.
// master = issue/ROB side, slave = register file.
interface regfile_tagged_if;
  import regfile_tagged_pkg::*;

  logic                  rename_valid;
  logic [IDX_W-1:0]      rename_rd_idx;
  logic [TAG_W-1:0]      rename_tag;

  logic                  cdb_active;
  logic [TAG_W-1:0]      cdb_tag;
  logic [XLEN-1:0]       cdb_val;
  logic [IDX_W-1:0]      cdb_rd_idx;

  logic                  predict_fail;

  logic [IDX_W-1:0]      rs1_idx;
  logic [XLEN-1:0]       rs1_val;
  logic [TAG_W-1:0]      rs1_tag;
  logic [IDX_W-1:0]      rs2_idx;
  logic [XLEN-1:0]       rs2_val;
  logic [TAG_W-1:0]      rs2_tag;

  modport master (
    output rename_valid, rename_rd_idx, rename_tag,
    output cdb_active, cdb_tag, cdb_val, cdb_rd_idx,
    output predict_fail,
    output rs1_idx, rs2_idx,
    input  rs1_val, rs1_tag, rs2_val, rs2_tag
  );

  modport slave (
    input  rename_valid, rename_rd_idx, rename_tag,
    input  cdb_active, cdb_tag, cdb_val, cdb_rd_idx,
    input  predict_fail,
    input  rs1_idx, rs2_idx,
    output rs1_val, rs1_tag, rs2_val, rs2_tag
  );

endinterface

// File: rtl/regfile_read_bypass.sv
// One combinational read port: stored value/tag, overridden by the commit
// broadcast when the committing tag is exactly the producer being waited on.
module regfile_read_bypass
  import regfile_tagged_pkg::*;
(
  input  logic [IDX_W-1:0] idx_i,
  input  logic [XLEN-1:0]  st_val_i,
  input  logic [TAG_W-1:0] st_tag_i,
  input  logic             cdb_active_i,
  input  logic [TAG_W-1:0] cdb_tag_i,
  input  logic [XLEN-1:0]  cdb_val_i,
  output rd_rsp_t          rsp_o
);

  logic hit;

  // x0 never bypasses; a ready register (tag none) never matches a commit.
  assign hit = cdb_active_i && (idx_i != '0) && (st_tag_i != TAG_NONE) &&
               (st_tag_i == cdb_tag_i);

  // Select committed value or stored state.
  always_comb begin
    rsp_o.val = st_val_i;
    rsp_o.tag = st_tag_i;
    if (hit) begin
      rsp_o.val = cdb_val_i;
      rsp_o.tag = TAG_NONE;
    end
  end

endmodule

// File: rtl/regfile_tagged.sv
// Architectural register file with per-register rename tags.
// Renames from issue, value write-back + tag clear from ROB commit,
// two combinational read ports with same-cycle commit bypass.
// Optional build macro: REGFILE_COMMIT_TRACE_EN prints each commit in simulation.
module regfile_tagged
  import regfile_tagged_pkg::*;
(
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  regfile_tagged_if.slave   rf
);

  localparam int NUM_PORTS = 2;

  logic [REG_NUM-1:0][XLEN-1:0]  val_q, val_d;
  logic [REG_NUM-1:0][TAG_W-1:0] tag_q, tag_d;

  logic commit_en;
  logic rename_en;

  assign commit_en = rf.cdb_active && (rf.cdb_rd_idx != '0);
  assign rename_en = rf.rename_valid && !rf.predict_fail && (rf.rename_rd_idx != '0);

  // Next state: commit first, then flush or rename on top (rename wins the tag).
  always_comb begin
    val_d = val_q;
    tag_d = tag_q;
    if (rdy_in) begin
      if (commit_en) begin
        val_d[rf.cdb_rd_idx] = rf.cdb_val;
        // A younger rename of the same rd keeps its tag.
        if (tag_q[rf.cdb_rd_idx] == rf.cdb_tag)
          tag_d[rf.cdb_rd_idx] = TAG_NONE;
      end
      if (rf.predict_fail)
        tag_d = '0;
      else if (rename_en)
        tag_d[rf.rename_rd_idx] = rf.rename_tag;
    end
    val_d[0] = '0;
    tag_d[0] = TAG_NONE;
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      val_q <= '0;
      tag_q <= '0;
    end else begin
      val_q <= val_d;
      tag_q <= tag_d;
    end
  end

  logic    [NUM_PORTS-1:0][IDX_W-1:0] rd_idx;
  rd_rsp_t [NUM_PORTS-1:0]            rd_rsp;

  assign rd_idx = {rf.rs2_idx, rf.rs1_idx};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd
    regfile_read_bypass u_rd (
      .idx_i        (rd_idx[p]),
      .st_val_i     (val_q[rd_idx[p]]),
      .st_tag_i     (tag_q[rd_idx[p]]),
      .cdb_active_i (rf.cdb_active),
      .cdb_tag_i    (rf.cdb_tag),
      .cdb_val_i    (rf.cdb_val),
      .rsp_o        (rd_rsp[p])
    );
  end

  assign rf.rs1_val = rd_rsp[0].val;
  assign rf.rs1_tag = rd_rsp[0].tag;
  assign rf.rs2_val = rd_rsp[1].val;
  assign rf.rs2_tag = rd_rsp[1].tag;

`ifdef REGFILE_COMMIT_TRACE_EN
  // Simulation-only commit trace.
  always @(posedge clk_in) begin
    if (!rst_in && rdy_in && commit_en)
      $display("RF: x%0d <= %0h tag=%0d cleared=%0d", rf.cdb_rd_idx, rf.cdb_val,
               rf.cdb_tag, (tag_q[rf.cdb_rd_idx] == rf.cdb_tag));
  end
`else
`endif

endmodule

// File: tb/tb_regfile_tagged.sv
// Self-checking bench for regfile_tagged: directed scenarios plus a
// randomized run against a behavioural array model.
module tb_regfile_tagged;
  import regfile_tagged_pkg::*;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic rdy_in = 1'b1;

  regfile_tagged_if rf_if ();

  regfile_tagged dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .rf     (rf_if)
  );

  always #5 clk_in = ~clk_in;

  int n_tests = 0;
  int n_fail  = 0;

  logic [XLEN-1:0]  m_val [REG_NUM];
  logic [TAG_W-1:0] m_tag [REG_NUM];

  task automatic model_clear();
    for (int i = 0; i < REG_NUM; i++) begin
      m_val[i] = '0;
      m_tag[i] = '0;
    end
  endtask

  task automatic idle();
    rdy_in              = 1'b1;
    rf_if.rename_valid  = 1'b0;
    rf_if.rename_rd_idx = '0;
    rf_if.rename_tag    = '0;
    rf_if.cdb_active    = 1'b0;
    rf_if.cdb_tag       = '0;
    rf_if.cdb_val       = '0;
    rf_if.cdb_rd_idx    = '0;
    rf_if.predict_fail  = 1'b0;
  endtask

  // Advance one clock; update the model from the inputs seen at the edge.
  task automatic tick();
    int rd;
    @(posedge clk_in);
    if (rst_in) model_clear();
    else if (rdy_in) begin
      if (rf_if.cdb_active && rf_if.cdb_rd_idx != 0) begin
        rd = int'(rf_if.cdb_rd_idx);
        m_val[rd] = rf_if.cdb_val;
        if (m_tag[rd] == rf_if.cdb_tag) m_tag[rd] = '0;
      end
      if (rf_if.predict_fail) begin
        for (int i = 0; i < REG_NUM; i++) m_tag[i] = '0;
      end else if (rf_if.rename_valid && rf_if.rename_rd_idx != 0)
        m_tag[int'(rf_if.rename_rd_idx)] = rf_if.rename_tag;
    end
    #1;
  endtask

  function automatic logic [XLEN-1:0] exp_val(input logic [IDX_W-1:0] idx);
    if (rf_if.cdb_active && idx != 0 && m_tag[idx] != 0 && m_tag[idx] == rf_if.cdb_tag)
      return rf_if.cdb_val;
    return m_val[idx];
  endfunction

  function automatic logic [TAG_W-1:0] exp_tag(input logic [IDX_W-1:0] idx);
    if (rf_if.cdb_active && idx != 0 && m_tag[idx] != 0 && m_tag[idx] == rf_if.cdb_tag)
      return '0;
    return m_tag[idx];
  endfunction

  // Async reset raised between edges must clear reads at once.
  task automatic test_reset();
    int bad;
    #2;
    rst_in = 1'b1;
    #1;
    rf_if.rs1_idx = 5'd5;
    #1;
    model_clear();
    n_tests++;
    if (rf_if.rs1_val !== '0 || rf_if.rs1_tag !== '0) begin
      n_fail++;
      $display("FAIL reset_rs1 got val=%h tag=%0d want 0/0", rf_if.rs1_val, rf_if.rs1_tag);
    end
    bad = 0;
    for (int i = 0; i < REG_NUM; i++) begin
      rf_if.rs2_idx = IDX_W'(i);
      #1;
      if (rf_if.rs2_val !== '0 || rf_if.rs2_tag !== '0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_all got %0d nonzero regs want 0", bad);
    end
    @(negedge clk_in);
    rst_in = 1'b0;
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_rename_commit();
    idle();
    rf_if.rename_valid = 1'b1; rf_if.rename_rd_idx = 5'd3; rf_if.rename_tag = 4'd2;
    tick();
    idle();
    rf_if.rs1_idx = 5'd3;
    #1;
    n_tests++;
    if (rf_if.rs1_tag !== 4'd2) begin
      n_fail++;
      $display("FAIL rename_tag got %0d want 2", rf_if.rs1_tag);
    end
    rf_if.cdb_active = 1'b1; rf_if.cdb_tag = 4'd2; rf_if.cdb_rd_idx = 5'd3;
    rf_if.cdb_val = 32'hDEADBEEF;
    #1;
    n_tests++;
    if (rf_if.rs1_val !== 32'hDEADBEEF || rf_if.rs1_tag !== 4'd0) begin
      n_fail++;
      $display("FAIL commit_bypass got %h/%0d want deadbeef/0", rf_if.rs1_val, rf_if.rs1_tag);
    end
    tick();
    idle();
    #1;
    n_tests++;
    if (rf_if.rs1_val !== 32'hDEADBEEF || rf_if.rs1_tag !== 4'd0) begin
      n_fail++;
      $display("FAIL commit_stored got %h/%0d want deadbeef/0", rf_if.rs1_val, rf_if.rs1_tag);
    end
  endtask

  task automatic test_stale_commit();
    idle();
    rf_if.rename_valid = 1'b1; rf_if.rename_rd_idx = 5'd7; rf_if.rename_tag = 4'd1;
    tick();
    rf_if.rename_tag = 4'd4;
    tick();
    idle();
    rf_if.cdb_active = 1'b1; rf_if.cdb_tag = 4'd1; rf_if.cdb_rd_idx = 5'd7;
    rf_if.cdb_val = 32'h11;
    rf_if.rs2_idx = 5'd7;
    #1;
    n_tests++;
    if (rf_if.rs2_tag !== 4'd4 || rf_if.rs2_val !== 32'h0) begin
      n_fail++;
      $display("FAIL stale_no_bypass got %h/%0d want 0/4", rf_if.rs2_val, rf_if.rs2_tag);
    end
    tick();
    idle();
    #1;
    n_tests++;
    if (rf_if.rs2_val !== 32'h11 || rf_if.rs2_tag !== 4'd4) begin
      n_fail++;
      $display("FAIL stale_commit got %h/%0d want 11/4", rf_if.rs2_val, rf_if.rs2_tag);
    end
  endtask

  task automatic test_simultaneous();
    idle();
    rf_if.rename_valid = 1'b1; rf_if.rename_rd_idx = 5'd9; rf_if.rename_tag = 4'd6;
    tick();
    rf_if.cdb_active = 1'b1; rf_if.cdb_tag = 4'd6; rf_if.cdb_rd_idx = 5'd9;
    rf_if.cdb_val = 32'h55;
    tick();
    idle();
    rf_if.rs1_idx = 5'd9;
    #1;
    n_tests++;
    if (rf_if.rs1_val !== 32'h55 || rf_if.rs1_tag !== 4'd6) begin
      n_fail++;
      $display("FAIL simultaneous got %h/%0d want 55/6", rf_if.rs1_val, rf_if.rs1_tag);
    end
  endtask

  task automatic test_flush();
    int bad;
    idle();
    rf_if.rename_valid = 1'b1; rf_if.rename_rd_idx = 5'd1; rf_if.rename_tag = 4'd1;
    tick();
    rf_if.rename_rd_idx = 5'd2; rf_if.rename_tag = 4'd5;
    tick();
    rf_if.predict_fail = 1'b1;
    rf_if.rename_rd_idx = 5'd4; rf_if.rename_tag = 4'd3;
    rf_if.cdb_active = 1'b1; rf_if.cdb_tag = 4'd1; rf_if.cdb_rd_idx = 5'd1;
    rf_if.cdb_val = 32'h77;
    tick();
    idle();
    bad = 0;
    for (int i = 0; i < REG_NUM; i++) begin
      rf_if.rs2_idx = IDX_W'(i);
      #1;
      if (rf_if.rs2_tag !== '0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL flush_tags got %0d pending regs want 0", bad);
    end
    rf_if.rs1_idx = 5'd1;
    #1;
    n_tests++;
    if (rf_if.rs1_val !== 32'h77 || rf_if.rs1_tag !== 4'd0) begin
      n_fail++;
      $display("FAIL flush_commit got %h/%0d want 77/0", rf_if.rs1_val, rf_if.rs1_tag);
    end
  endtask

  task automatic test_x0_rdy();
    idle();
    rf_if.rename_valid = 1'b1; rf_if.rename_rd_idx = 5'd0; rf_if.rename_tag = 4'd5;
    rf_if.cdb_active = 1'b1; rf_if.cdb_tag = 4'd5; rf_if.cdb_rd_idx = 5'd0;
    rf_if.cdb_val = 32'h99;
    rf_if.rs1_idx = 5'd0;
    tick();
    idle();
    #1;
    n_tests++;
    if (rf_if.rs1_val !== '0 || rf_if.rs1_tag !== '0) begin
      n_fail++;
      $display("FAIL x0 got %h/%0d want 0/0", rf_if.rs1_val, rf_if.rs1_tag);
    end
    rdy_in = 1'b0;
    rf_if.rename_valid = 1'b1; rf_if.rename_rd_idx = 5'd8; rf_if.rename_tag = 4'd2;
    rf_if.cdb_active = 1'b1; rf_if.cdb_tag = 4'd0; rf_if.cdb_rd_idx = 5'd10;
    rf_if.cdb_val = 32'hAB;
    tick();
    idle();
    rf_if.rs1_idx = 5'd8;
    rf_if.rs2_idx = 5'd10;
    #1;
    n_tests++;
    if (rf_if.rs1_tag !== 4'd0 || rf_if.rs2_val !== 32'h0) begin
      n_fail++;
      $display("FAIL rdy_hold got tag8=%0d val10=%h want 0/0", rf_if.rs1_tag, rf_if.rs2_val);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      idle();
      rdy_in              = ($urandom_range(0, 9) != 0);
      rf_if.rename_valid  = $urandom_range(0, 1) == 1;
      rf_if.rename_rd_idx = IDX_W'($urandom_range(0, REG_NUM - 1));
      rf_if.rename_tag    = TAG_W'($urandom_range(1, 15));
      rf_if.cdb_active    = $urandom_range(0, 1) == 1;
      rf_if.cdb_rd_idx    = IDX_W'($urandom_range(0, REG_NUM - 1));
      if ($urandom_range(0, 9) < 7) rf_if.cdb_tag = m_tag[rf_if.cdb_rd_idx];
      else                          rf_if.cdb_tag = TAG_W'($urandom_range(0, 15));
      rf_if.cdb_val       = $urandom;
      rf_if.predict_fail  = ($urandom_range(0, 19) == 0);
      rf_if.rs1_idx       = IDX_W'($urandom_range(0, REG_NUM - 1));
      if ($urandom_range(0, 3) == 0) rf_if.rs1_idx = rf_if.cdb_rd_idx;
      rf_if.rs2_idx       = ($urandom_range(0, 4) == 0) ? rf_if.rs1_idx
                                                        : IDX_W'($urandom_range(0, REG_NUM - 1));
      #1;
      n_tests++;
      if (rf_if.rs1_val !== exp_val(rf_if.rs1_idx) || rf_if.rs1_tag !== exp_tag(rf_if.rs1_idx)) begin
        n_fail++;
        $display("FAIL rand_rs1 cyc=%0d x%0d got %h/%0d want %h/%0d", c, rf_if.rs1_idx,
                 rf_if.rs1_val, rf_if.rs1_tag, exp_val(rf_if.rs1_idx), exp_tag(rf_if.rs1_idx));
      end
      n_tests++;
      if (rf_if.rs2_val !== exp_val(rf_if.rs2_idx) || rf_if.rs2_tag !== exp_tag(rf_if.rs2_idx)) begin
        n_fail++;
        $display("FAIL rand_rs2 cyc=%0d x%0d got %h/%0d want %h/%0d", c, rf_if.rs2_idx,
                 rf_if.rs2_val, rf_if.rs2_tag, exp_val(rf_if.rs2_idx), exp_tag(rf_if.rs2_idx));
      end
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    rf_if.rs1_idx = '0;
    rf_if.rs2_idx = '0;
    model_clear();
    test_reset();
    test_rename_commit();
    test_stale_commit();
    test_simultaneous();
    test_flush();
    test_x0_rdy();
    test_random();
    test_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
